// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall/flush/forwarding control for the 5-stage RV32I pipeline,
//             including multi-cycle data-memory wait sequencing with watchdog.
//  Options  : HAZARD_PERF_EN adds stall/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REGW        = 5,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] Rs1E,
    input  logic [REGW-1:0] Rs2E,
    input  logic [REGW-1:0] RdE,
    input  logic [REGW-1:0] RdM,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            LoadE,
    input  logic            PCSrcE,
    input  logic            MemReqM,
    input  logic            MemReadyM,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushW,
    output logic            MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     PerfStallCnt,
    output logic [31:0]     PerfFlushCnt
`endif
);

    localparam logic [TMO_W-1:0] C_TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] C_CNT_ONE   = TMO_W'(1);
    localparam logic [1:0]       C_FWD_RF    = 2'b00;
    localparam logic [1:0]       C_FWD_MEM   = 2'b10;
    localparam logic [1:0]       C_FWD_WB    = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             lwStall;
    logic             mem_miss;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Memory stage result is younger than writeback, so it wins on a tie.
    function automatic logic [1:0] fwd_sel(
        input logic [REGW-1:0] rs,
        input logic [REGW-1:0] rd_m,
        input logic [REGW-1:0] rd_w,
        input logic            we_m,
        input logic            we_w
    );
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (rs != '0) begin
            if (we_m && (rd_m == rs)) begin
                sel = C_FWD_MEM;
            end else if (we_w && (rd_w == rs)) begin
                sel = C_FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a    = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
        fwd_b    = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
        lwStall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_miss = MemReqM && !MemReadyM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MemErr    = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    // Freeze the pipe in the very cycle the miss is seen.
                    state_d = MEM_WAIT;
                    cnt_d   = C_CNT_ONE;
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    FlushW  = 1'b1;
                end else begin
                    StallF = lwStall;
                    StallD = lwStall;
                    FlushD = PCSrcE;
                    FlushE = lwStall | PCSrcE;
                end
            end
            MEM_WAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                if (MemReadyM) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == C_TMO_LIMIT) begin
                    state_d = MEM_ERR;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            MEM_ERR: begin
                // Drop the faulting access out of M; only the PC is held.
                MemErr  = 1'b1;
                StallF  = 1'b1;
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushW  = 1'b1;
                state_d = RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (reset) begin
            ForwardAE = C_FWD_RF;
            ForwardBE = C_FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushW    = 1'b0;
            MemErr    = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(StallF);
            perf_flush_q <= perf_flush_q + 32'(FlushE);
        end
    end

    assign PerfStallCnt = perf_stall_q;
    assign PerfFlushCnt = perf_flush_q;
`endif

endmodule
`default_nettype wire
